// File: rtl/alu_pkg.sv
// Shared opcode encodings and defaults for the Bully datapath ALU.
package alu_pkg;

  localparam int ALU_BUS_WIDTH = 32;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NUL = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_XOR = 4'b0011;
  localparam opcode_t OP_AND = 4'b0100;
  localparam opcode_t OP_OR  = 4'b1000;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between register-file reads and the ALU.
interface alu_if
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = ALU_BUS_WIDTH
) ();

  opcode_t              opcode;
  logic [BUS_WIDTH-1:0] num_0;
  logic [BUS_WIDTH-1:0] num_1;
  logic [BUS_WIDTH-1:0] num_out;
  logic                 over_flag;
  logic                 zero_flag;
  logic                 greater_flag;
  logic                 equal_flag;

  modport master (
    output opcode,
    output num_0,
    output num_1,
    input  num_out,
    input  over_flag,
    input  zero_flag,
    input  greater_flag,
    input  equal_flag
  );

  modport slave (
    input  opcode,
    input  num_0,
    input  num_1,
    output num_out,
    output over_flag,
    output zero_flag,
    output greater_flag,
    output equal_flag
  );

endinterface

// File: rtl/alu_comb.sv
// Combinational ALU core: result plus overflow/zero/greater/equal flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = ALU_BUS_WIDTH
) (
  input  opcode_t              opcode_i,
  input  logic [BUS_WIDTH-1:0] num_0_i,
  input  logic [BUS_WIDTH-1:0] num_1_i,
  output logic [BUS_WIDTH-1:0] result_o,
  output logic                 over_o,
  output logic                 zero_o,
  output logic                 greater_o,
  output logic                 equal_o
);

  localparam int MSB = BUS_WIDTH - 1;

  logic is_add;
  logic is_sub;
  logic is_xor;
  logic is_and;
  logic is_or;

  assign is_add = (opcode_i == OP_ADD);
  assign is_sub = (opcode_i == OP_SUB);
  assign is_xor = (opcode_i == OP_XOR);
  assign is_and = (opcode_i == OP_AND);
  assign is_or  = (opcode_i == OP_OR);

  logic [BUS_WIDTH-1:0] addend;
  logic [BUS_WIDTH-1:0] cin;
  logic [BUS_WIDTH-1:0] sum;
  logic                 sum_ov;

  // SUB reuses the adder as num_0 + ~num_1 + 1
  assign addend = is_sub ? ~num_1_i : num_1_i;
  assign cin    = {{(BUS_WIDTH-1){1'b0}}, is_sub};
  assign sum    = num_0_i + addend + cin;

  // Same-sign adder inputs with a flipped result sign
  assign sum_ov = (num_0_i[MSB] == addend[MSB]) &&
                  (sum[MSB] != num_0_i[MSB]);

  always_comb begin
    result_o = '0;
    over_o   = 1'b0;
    unique case (1'b1)
      is_add,
      is_sub: begin
        result_o = sum;
        over_o   = sum_ov;
      end
      is_xor: result_o = num_0_i ^ num_1_i;
      is_and: result_o = num_0_i & num_1_i;
      is_or:  result_o = num_0_i | num_1_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o    = (result_o == '0);
  assign greater_o = ($signed(num_0_i) > $signed(num_1_i));
  assign equal_o   = (num_0_i == num_1_i);

endmodule

// File: rtl/alu_unit.sv
// Registered integer ALU: one operation per cycle, one cycle of latency.
module alu_unit
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = ALU_BUS_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  logic [BUS_WIDTH-1:0] num_out_d;
  logic [BUS_WIDTH-1:0] num_out_q;
  logic                 over_d;
  logic                 over_q;
  logic                 zero_d;
  logic                 zero_q;
  logic                 greater_d;
  logic                 greater_q;
  logic                 equal_d;
  logic                 equal_q;

  alu_comb #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_comb (
    .opcode_i  (bus.opcode),
    .num_0_i   (bus.num_0),
    .num_1_i   (bus.num_1),
    .result_o  (num_out_d),
    .over_o    (over_d),
    .zero_o    (zero_d),
    .greater_o (greater_d),
    .equal_o   (equal_d)
  );

  // Zero flag resets high to stay consistent with a zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_out_q <= '0;
      over_q    <= 1'b0;
      zero_q    <= 1'b1;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      num_out_q <= num_out_d;
      over_q    <= over_d;
      zero_q    <= zero_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
    end
  end

  assign bus.num_out      = num_out_q;
  assign bus.over_flag    = over_q;
  assign bus.zero_flag    = zero_q;
  assign bus.greater_flag = greater_q;
  assign bus.equal_flag   = equal_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed vectors, random ops, async resets.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    string        name;
    logic [W-1:0] r;
    logic         ov;
    logic         z;
    logic         gt;
    logic         eq;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb_q[$];

  alu_if #(.BUS_WIDTH(W)) bus ();

  alu_unit #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed arithmetic on 64-bit values, overflow from range
  function automatic exp_t model(string nm, logic [3:0] op,
                                 logic [W-1:0] a, logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = 0;
    e.name = nm;
    e.r  = '0;
    e.ov = 1'b0;
    case (op)
      4'b0001: begin
        t = sa + sb;
        e.r = W'(t);
      end
      4'b0010: begin
        t = sa - sb;
        e.r = W'(t);
      end
      4'b0011: e.r = a ^ b;
      4'b0100: e.r = a & b;
      4'b1000: e.r = a | b;
      default: e.r = '0;
    endcase
    if (op == 4'b0001 || op == 4'b0010)
      e.ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    e.z  = (e.r == 0);
    e.gt = sa > sb;
    e.eq = (a == b);
    return e;
  endfunction

  task automatic compare(string nm, exp_t e);
    logic [W+3:0] act;
    logic [W+3:0] req;
    act = {bus.num_out, bus.over_flag, bus.zero_flag,
           bus.greater_flag, bus.equal_flag};
    req = {e.r, e.ov, e.z, e.gt, e.eq};
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got out=%h ov/z/gt/eq=%b want out=%h ov/z/gt/eq=%b",
               nm, act[W+3:4], act[3:0], req[W+3:4], req[3:0]);
    end
  endtask

  task automatic issue(string nm, logic [3:0] op,
                       logic [W-1:0] a, logic [W-1:0] b);
    @(negedge clk);
    bus.opcode = op;
    bus.num_0  = a;
    bus.num_1  = b;
    sb_q.push_back(model(nm, op, a, b));
  endtask

  task automatic check_reset(string nm);
    exp_t e;
    e.name = nm;
    e.r  = '0;
    e.ov = 1'b0;
    e.z  = 1'b1;
    e.gt = 1'b0;
    e.eq = 1'b0;
    compare(nm, e);
  endtask

  // Mid-cycle reset: in-flight op is dropped, outputs stay reset over an edge
  task automatic pulse_reset(string nm);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset({nm, "_async"});
    @(posedge clk);
    #1;
    check_reset({nm, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every result is presented one edge after its inputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare(e.name, e);
      end
    end
  end

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'h7fff_ffff;
      2: v = 32'h8000_0000;
      3: v = 32'hffff_ffff;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b1000, 4'b1111};
    if ($urandom_range(0, 9) == 0)
      return 4'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    int wait_cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus.opcode = OP_ADD;
    bus.num_0  = 32'd3;
    bus.num_1  = 32'd4;
    sb_q.push_back(model("pre_add", OP_ADD, 32'd3, 32'd4));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    issue("add_1_1", OP_ADD, 32'd1, 32'd1);

    issue("add_a", OP_ADD, 32'hffff_fff1, 32'h0000_0001);
    issue("add_zero", OP_ADD, 32'hffff_fff1, 32'h0000_000f);
    issue("add_ovf", OP_ADD, 32'h7e7e_7e7e, 32'h5555_aaaa);
    issue("add_carry", OP_ADD, 32'h0000_ffff, 32'h0000_ffff);
    issue("sub_a", OP_SUB, 32'h0000_0001, 32'hffff_fff1);
    issue("sub_eq", OP_SUB, 32'h0000_ffff, 32'h0000_ffff);
    issue("sub_b", OP_SUB, 32'h7e7e_7e7e, 32'h5555_aaaa);
    issue("sub_ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001);
    issue("and", OP_AND, 32'h7e7e_7e7e, 32'h5555_aaaa);
    issue("or", OP_OR, 32'h7e7e_7e7e, 32'h5555_aaaa);
    issue("xor", OP_XOR, 32'h7e7e_7e7e, 32'h5555_aaaa);
    issue("nul", OP_NUL, 32'hffff_fff1, 32'h0000_0001);
    issue("op_f", 4'b1111, 32'hffff_fff1, 32'h0000_0001);
    issue("nul_swap", OP_NUL, 32'h0000_0001, 32'hffff_fff1);
    issue("op_f_swap", 4'b1111, 32'h0000_0001, 32'hffff_fff1);

    issue("b2b_add", OP_ADD, 32'h1234_5678, 32'h1111_1111);
    issue("b2b_sub", OP_SUB, 32'h1234_5678, 32'h1111_1111);
    issue("b2b_xor", OP_XOR, 32'h1234_5678, 32'h1111_1111);
    issue("b2b_and", OP_AND, 32'h1234_5678, 32'h1111_1111);
    issue("b2b_or", OP_OR, 32'h1234_5678, 32'h1111_1111);
    issue("b2b_nul", OP_NUL, 32'h1234_5678, 32'h1111_1111);
    issue("b2b_lost", OP_ADD, 32'h0000_0005, 32'h0000_0006);
    pulse_reset("b2b_reset");
    issue("b2b_after", OP_SUB, 32'h0000_0009, 32'h0000_0002);

    for (int i = 0; i < 300; i++) begin
      issue($sformatf("rnd%0d", i), rand_op(),
            rand_operand(), rand_operand());
      if (i == 150)
        pulse_reset("rnd_reset");
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Registered integer ALU for the Bully datapath. Each rising clock edge it takes two BUS_WIDTH-bit operands and a 4-bit opcode and performs one of: add, subtract, AND, OR, XOR or null. It registers the result together with overflow, zero, greater-than and equal status flags. It sits between the register-file read ports and the write-back / branch-decision logic.

## Interface
- BUS_WIDTH, default 32: operand and result width in bits; must be at least 2.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, asynchronous and active-low.
- opcode  input  4: operation select (encodings under Operation).
- num_0  input  BUS_WIDTH: first operand, the minuend for SUB.
- num_1  input  BUS_WIDTH: second operand, the subtrahend for SUB.
- num_out  output  BUS_WIDTH: registered result.
- over_flag  output  1: registered two's-complement overflow of ADD/SUB.
- zero_flag  output  1: registered "num_out == 0".
- greater_flag  output  1: registered signed num_0 > num_1.
- equal_flag  output  1: registered num_0 == num_1.

## Operation
- Opcodes:
  - NUL 4'b0000: result 0.
  - ADD 4'b0001: result num_0 + num_1.
  - SUB 4'b0010: result num_0 − num_1.
  - XOR 4'b0011: result num_0 ^ num_1.
  - AND 4'b0100: result num_0 & num_1.
  - OR 4'b1000: result num_0 | num_1.
  - Any other encoding behaves exactly as NUL.
- Arithmetic is modulo 2^BUS_WIDTH. The carry/borrow out of the MSB is discarded and not reported.
- over_flag:
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when the operands differ in sign and the result sign differs from num_0.
  - All other opcodes: 0.
- zero_flag is derived from the computed result, so it is also 1 for NUL.
- greater_flag and equal_flag are computed from the operands for every opcode, independent of the operation selected.
- greater_flag uses a signed two's-complement comparison.

## Timing
- Latency is 1 cycle. Inputs present before rising edge N appear on all outputs after edge N.
- There is no handshake and no enable: the unit accepts a new operation every cycle.
- Outputs are pure registers, with no combinational path from inputs to outputs.
- While rst_n is low, outputs are forced immediately, without waiting for a clock edge:
  - num_out = 0
  - over_flag = 0
  - zero_flag = 1 (consistent with num_out = 0)
  - greater_flag = 0
  - equal_flag = 0
- Reset asserted mid-stream discards the operation in flight. The first edge after rst_n deasserts captures fresh inputs.
- Any opcode and operand change between edges simply yields the new result on the next edge; there is no hold or hazard state.

## Structure
- Shared package alu_pkg holds:
  - the six opcode localparams (NUL/ADD/SUB/XOR/AND/OR);
  - an opcode typedef of 4 bits;
  - the default BUS_WIDTH.
- A single combinational sub-module alu_comb computes the result and the four flags; the top adds only the output register stage.
- SUB is implemented as num_0 + ~num_1 + 1 through the same adder as ADD.

## Test plan
- Reset: drive rst_n low with no clock edge -> all outputs immediately at reset values (num_out 0, zero_flag 1, others 0). Release, then ADD 1+1 -> num_out 2 one cycle later.
- ADD, BUS_WIDTH 32:
  - fffffff1+00000001 -> fffffff2, over 0, zero 0.
  - fffffff1+0000000f -> 00000000, zero 1, over 0.
  - 7e7e7e7e+5555aaaa -> d3d42928, over 1.
  - 0000ffff+0000ffff -> 0001fffe.
- SUB:
  - 00000001−fffffff1 -> 00000010, over 0, greater 1.
  - 0000ffff−0000ffff -> 0, zero 1, equal 1.
  - 7e7e7e7e−5555aaaa -> 2928d3d4, over 0.
  - 80000000−00000001 -> 7fffffff, over 1.
- Logic ops on 7e7e7e7e / 5555aaaa:
  - AND -> 54542a2a.
  - OR -> 7f7ffefe.
  - XOR -> 2b2bd4d4.
  - over 0 for all three.
- NUL and unused opcode 4'b1111 with fffffff1 / 00000001 -> num_out 0, zero 1, over 0, greater 0, equal 0. Swapped operands -> greater 1.
- Back-to-back: change opcode every cycle through all six operations -> each result appears exactly one edge after its inputs. Assert rst_n mid-sequence -> outputs reset asynchronously, and the result in flight is lost.
